mem_stage_ctrl: RTL and testbench

- Memory-stage sequencer that produces the write side of the MEM/WB pipeline register.
- Issues the data-memory request for the instruction in MEM and waits for dhit.
- Drives EN, flush and load data into MEM/WB, and raises a stall back to IF/ID/EX/MEM while a miss is outstanding.
- Never loses load data that returns while the downstream stage is frozen, and tracks halt and stuck-request conditions.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/sat_counter.sv | 40 ++++
 rtl/mem_stage_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the memory-stage sequencer and its helpers.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
//
// Contents:
//   memctrl_state_t  - 2-bit state of the MEM-stage request sequencer
//   TIMEOUT_CYC_DEF  - default number of request cycles before err is flagged
//   is_memop()       - true when the MEM slot carries a load or a store
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } memctrl_state_t;

  localparam int TIMEOUT_CYC_DEF = 1024;
  localparam int CNT_W_DEF       = 16;

  function automatic logic is_memop(input logic valid, input logic ren, input logic wen);
    return valid & (ren | wen);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a restart input.
// Latency: count updates one cycle after inc/clr are sampled.
// Backpressure: none; inc at MAX simply holds the count.
//
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset, count -> 0
//   clr  - restart the count from zero this cycle
//   inc  - count this cycle (combined with clr the result is 1)
//   cnt  - current count, never exceeds MAX
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Start point for this cycle's increment: a restart discards the old count
  // so that clr+inc yields 1, which lets a new request count its first cycle.
  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : cnt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc && (base != MAX)) begin
      cnt <= base + W'(1);
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer driving the write side of MEM/WB.
// Latency: zero-wait hits complete in the request cycle; misses complete on the dhit cycle.
// Backpressure: stall_o freezes IF/ID/EX/MEM while a miss is outstanding; freeze_i parks returned data.
//
// Ports:
//   CLK, RST                  - clock and synchronous active-high reset
//   mem_valid_i, dREN_i, dWEN_i, addr_i, store_i, halt_i
//                             - instruction currently in MEM (held stable by stall_o)
//   freeze_i                  - global downstream freeze
//   dhit, dmemload            - cache completion strobe and read data
//   dmemREN/WEN/addr/store    - cache request
//   mw_en_o, mw_flush_o, dmemload_o
//                             - MEM/WB register write controls and load data
//   stall_o                   - upstream freeze while busy
//   halt_o, err_o             - sticky halted / request-timeout flags
//   stall_cnt_o               - saturating count of stall_o cycles
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mem_valid_i,
  input  logic             dREN_i,
  input  logic             dWEN_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      store_i,
  input  logic             halt_i,
  input  logic             freeze_i,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mw_en_o,
  output logic             mw_flush_o,
  output logic [31:0]      dmemload_o,
  output logic             stall_o,
  output logic             halt_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  memctrl_state_t state_q, state_d;

  logic [31:0]      load_q;
  logic             load_cap;   // park dmemload because MEM/WB is frozen
  logic             load_sel;   // present parked data instead of the live bus
  logic             wait_clr;
  logic             wait_inc;
  logic             err_set;
  logic [CNT_W-1:0] wait_cnt;
  logic             memop;
  logic             req_rd;
  logic             req_wr;

  // Address and store data are pure pass-through; upstream stall keeps them
  // stable for the whole request.
  assign dmemaddr  = addr_i;
  assign dmemstore = store_i;

  assign memop  = is_memop(mem_valid_i, dREN_i, dWEN_i);
  // Load wins if both enables are set, so the cache never sees a dual request.
  assign req_rd = mem_valid_i & dREN_i;
  assign req_wr = mem_valid_i & dWEN_i & ~dREN_i;

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    mw_en_o    = 1'b0;
    mw_flush_o = 1'b0;
    stall_o    = 1'b0;
    load_cap   = 1'b0;
    load_sel   = 1'b0;
    wait_clr   = 1'b1;
    wait_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (memop) begin
          dmemREN = req_rd;
          dmemWEN = req_wr;
          if (dhit) begin
            if (!freeze_i) begin
              // Zero-wait completion: the instruction flows straight on.
              mw_en_o = 1'b1;
            end else begin
              load_cap = 1'b1;
              stall_o  = 1'b1;
              state_d  = HOLD;
            end
          end else begin
            // First request cycle counts towards the timeout.
            mw_flush_o = 1'b1;
            stall_o    = 1'b1;
            wait_inc   = 1'b1;
            state_d    = WAIT;
          end
        end else if (halt_i && mem_valid_i && !freeze_i) begin
          // Let the halt itself reach WB, then stop everything.
          mw_en_o = 1'b1;
          state_d = HALTED;
        end else begin
          mw_en_o = !freeze_i;
        end
      end

      WAIT: begin
        dmemREN = req_rd;
        dmemWEN = req_wr;
        if (dhit) begin
          if (!freeze_i) begin
            mw_en_o = 1'b1;
            state_d = IDLE;
          end else begin
            load_cap = 1'b1;
            stall_o  = 1'b1;
            state_d  = HOLD;
          end
        end else begin
          // Bubble into WB so the instruction is never written twice.
          mw_flush_o = 1'b1;
          stall_o    = 1'b1;
          wait_clr   = 1'b0;
          wait_inc   = 1'b1;
        end
      end

      HOLD: begin
        // Request already satisfied: keep the cache quiet so it cannot replay.
        stall_o  = 1'b1;
        load_sel = 1'b1;
        if (!freeze_i) begin
          mw_en_o = 1'b1;
          state_d = IDLE;
        end
      end

      HALTED: begin
        stall_o = 1'b1;
      end
    endcase

    if (RST) begin
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      mw_en_o    = 1'b0;
      mw_flush_o = 1'b1;
      stall_o    = 1'b0;
      load_sel   = 1'b0;
    end
  end

  assign dmemload_o = load_sel ? load_q : dmemload;

  // Timeout is flagged on the edge where the request-cycle count reaches
  // TIMEOUT_CYC; the request itself keeps waiting.
  always_comb begin
    err_set = 1'b0;
    if (wait_inc) begin
      if (wait_clr) begin
        err_set = (TIMEOUT_CYC <= 1);
      end else begin
        err_set = (wait_cnt >= CNT_W'(TIMEOUT_CYC - 1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      load_q  <= '0;
      halt_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_cap) begin
        load_q <= dmemload;
      end
      if (state_d == HALTED) begin
        halt_o <= 1'b1;
      end
      if (err_set) begin
        err_o <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  sat_counter #(
    .W   (CNT_W),
    .MAX (CNT_W'(TIMEOUT_CYC))
  ) u_wait_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (wait_clr),
    .inc (wait_inc),
    .cnt (wait_cnt)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (1'b0),
    .inc (stall_o),
    .cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model
// that tracks "request outstanding", "data parked", halt/err and stall count.
module tb_mem_stage_ctrl;

  localparam int T = 8;

  logic        CLK = 1'b0;
  logic        RST, mem_valid_i, dREN_i, dWEN_i, halt_i, freeze_i, dhit;
  logic [31:0] addr_i, store_i, dmemload;
  logic        dmemREN, dmemWEN, mw_en_o, mw_flush_o, stall_o, halt_o, err_o;
  logic [31:0] dmemaddr, dmemstore, dmemload_o;
  logic [15:0] stall_cnt_o;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.TIMEOUT_CYC(T), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .mem_valid_i(mem_valid_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
    .addr_i(addr_i), .store_i(store_i), .halt_i(halt_i), .freeze_i(freeze_i),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mw_en_o(mw_en_o),
    .mw_flush_o(mw_flush_o), .dmemload_o(dmemload_o), .stall_o(stall_o),
    .halt_o(halt_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_out;     // a request is outstanding (missed, not yet hit)
  int          m_n;       // request cycles spent without a hit
  bit          m_park;    // returned data waiting for the freeze to lift
  logic [31:0] m_pdata;
  bit          m_halt;
  bit          m_err;
  int          m_scnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        e_rd, e_wr, e_en, e_fl, e_st;
    logic [31:0] e_ld;
    bit          memop;
    e_rd = 0; e_wr = 0; e_en = 0; e_fl = 0; e_st = 0;
    e_ld = dmemload;
    memop = mem_valid_i && (dREN_i || dWEN_i);

    // registered outputs reflect the state before this edge
    chk("halt_o", halt_o, 32'(m_halt));
    chk("err_o", err_o, 32'(m_err));
    chk("stall_cnt_o", 32'(stall_cnt_o), 32'(m_scnt));

    if (RST) begin
      e_fl = 1;
      chk("rst_ren", dmemREN, 0);
      chk("rst_wen", dmemWEN, 0);
      chk("rst_en", mw_en_o, 0);
      chk("rst_flush", mw_flush_o, 1);
      chk("rst_stall", stall_o, 0);
      m_out = 0; m_n = 0; m_park = 0; m_pdata = 0; m_halt = 0; m_err = 0; m_scnt = 0;
      return;
    end

    if (m_halt) begin
      e_st = 1;
    end else if (m_park) begin
      e_st = 1;
      e_ld = m_pdata;
      e_en = !freeze_i;
      if (!freeze_i) m_park = 0;
    end else if (memop) begin
      e_rd = mem_valid_i && dREN_i;
      e_wr = mem_valid_i && dWEN_i && !dREN_i;
      if (dhit) begin
        m_out = 0;
        m_n   = 0;
        if (!freeze_i) begin
          e_en = 1;
        end else begin
          e_st    = 1;
          m_park  = 1;
          m_pdata = dmemload;
        end
      end else begin
        e_fl = 1;
        e_st = 1;
        m_n  = m_out ? ((m_n + 1 > T) ? T : m_n + 1) : 1;
        m_out = 1;
        if (m_n >= T) m_err = 1;
      end
    end else if (halt_i && mem_valid_i && !freeze_i) begin
      e_en   = 1;
      m_halt = 1;
    end else begin
      e_en = !freeze_i;
    end

    chk("dmemREN", dmemREN, 32'(e_rd));
    chk("dmemWEN", dmemWEN, 32'(e_wr));
    chk("dmemaddr", dmemaddr, addr_i);
    chk("dmemstore", dmemstore, store_i);
    chk("mw_en_o", mw_en_o, 32'(e_en));
    chk("mw_flush_o", mw_flush_o, 32'(e_fl));
    chk("stall_o", stall_o, 32'(e_st));
    chk("dmemload_o", dmemload_o, e_ld);
    if (e_st && m_scnt < 65535) m_scnt++;
  endtask

  task automatic drive(input logic r, input logic v, input logic rn, input logic wn,
                       input logic h, input logic f, input logic hit,
                       input logic [31:0] a, input logic [31:0] s, input logic [31:0] ld);
    @(negedge CLK);
    RST = r; mem_valid_i = v; dREN_i = rn; dWEN_i = wn; halt_i = h;
    freeze_i = f; dhit = hit; addr_i = a; store_i = s; dmemload = ld;
    #1;
    model_step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        r_v, r_rn, r_wn, r_h;
    logic [31:0] r_a, r_s;
    int          halted_cyc;
    int          hit_pct;

    RST = 1; mem_valid_i = 0; dREN_i = 0; dWEN_i = 0; halt_i = 0; freeze_i = 0;
    dhit = 0; addr_i = 0; store_i = 0; dmemload = 0;
    m_out = 0; m_n = 0; m_park = 0; m_pdata = 0; m_halt = 0; m_err = 0; m_scnt = 0;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555_0000);
    chk("lit_rst_halt", halt_o, 0);
    chk("lit_rst_err", err_o, 0);
    chk("lit_rst_scnt", 32'(stall_cnt_o), 0);
    chk("lit_rst_en", mw_en_o, 1);

    // Zero-wait load
    drive(0, 1, 1, 0, 0, 0, 1, 32'h100, 0, 32'hDEAD_BEEF);
    chk("lit_zw_en", mw_en_o, 1);
    chk("lit_zw_ld", dmemload_o, 32'hDEAD_BEEF);
    chk("lit_zw_stall", stall_o, 0);
    chk("lit_zw_ren", dmemREN, 1);

    // 3-cycle store miss
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 0, (i == 2), 32'h200, 32'h1234_5678, 32'(i));
      chk("lit_st_wen", dmemWEN, 1);
      chk("lit_st_addr", dmemaddr, 32'h200);
      chk("lit_st_data", dmemstore, 32'h1234_5678);
      chk("lit_st_stall", stall_o, (i < 2) ? 32'd1 : 32'd0);
      chk("lit_st_en", mw_en_o, (i == 2) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_st_scnt", 32'(stall_cnt_o), 2);

    // Load hit while frozen for 4 cycles
    drive(0, 1, 1, 0, 0, 1, 1, 32'h300, 0, 32'hCAFE_F00D);
    chk("lit_fz_en0", mw_en_o, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 1, 0, 32'h300, 0, 32'h1111_1111);
      chk("lit_fz_ren", dmemREN, 0);
      chk("lit_fz_en", mw_en_o, 0);
    end
    drive(0, 1, 1, 0, 0, 0, 0, 32'h300, 0, 32'h1111_1111);
    chk("lit_fz_rel_en", mw_en_o, 1);
    chk("lit_fz_rel_ld", dmemload_o, 32'hCAFE_F00D);

    // Timeout: dhit withheld for 10 cycles
    for (int i = 0; i < 11; i++) begin
      drive(0, 1, 1, 0, 0, 0, (i == 10), 32'h400, 0, $urandom);
      if (i == 7) chk("lit_to_pre", err_o, 0);
      if (i == 8) chk("lit_to_set", err_o, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_to_sticky", err_o, 1);

    // Reset in the middle of a miss
    drive(0, 1, 1, 0, 0, 0, 0, 32'h500, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 32'h500, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 32'h500, 0, 0);
    chk("lit_rw_ren", dmemREN, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h7777_7777);
    chk("lit_rw_err", err_o, 0);
    chk("lit_rw_halt", halt_o, 0);
    chk("lit_rw_scnt", 32'(stall_cnt_o), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_rw_stall", stall_o, 0);

    // Halt
    drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("lit_h_en", mw_en_o, 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 0, 0, 1, 32'h600, 0, 0);
      chk("lit_h_ren", dmemREN, 0);
      chk("lit_h_halt", halt_o, 1);
      chk("lit_h_stall", stall_o, 1);
      chk("lit_h_en0", mw_en_o, 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; the MEM instruction is held while the model says it
    // is still outstanding or parked, as a stalled pipeline would do.
    r_v = 0; r_rn = 0; r_wn = 0; r_h = 0; r_a = 0; r_s = 0;
    halted_cyc = 0;
    hit_pct = 35;
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) hit_pct = ($urandom_range(0, 1) == 0) ? 35 : 6;
      if (!(m_out || m_park)) begin
        int op;
        r_v  = ($urandom_range(0, 99) < 80);
        op   = $urandom_range(0, 9);
        r_rn = (op < 4) || (op == 9);
        r_wn = (op >= 4 && op < 7) || (op == 9);
        r_h  = !r_rn && !r_wn && ($urandom_range(0, 49) == 0);
        r_a  = $urandom;
        r_s  = $urandom;
      end
      drive(($urandom_range(0, 149) == 0) || (halted_cyc > 4), r_v, r_rn, r_wn, r_h,
            ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < hit_pct),
            r_a, r_s, $urandom);
      halted_cyc = m_halt ? halted_cyc + 1 : 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
